// File: rtl/fetch_buffer.sv
// Circular instruction queue between fetch and decode, with valid/ready on both sides and single-cycle flush.
// Optional same-cycle bypass when empty: define FETCH_BUFFER_BYPASS_EN.
module fetch_buffer #(
    parameter int DEPTH   = 8,
    parameter int INSTR_W = 32,
    parameter int PC_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [INSTR_W-1:0]         in_instr_i,
    input  logic [PC_W-1:0]            in_pc_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [INSTR_W-1:0]         out_instr_o,
    output logic [PC_W-1:0]            out_pc_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [INSTR_W-1:0] instr_mem_d [DEPTH];
    logic [PC_W-1:0]    pc_mem_q    [DEPTH];
    logic [PC_W-1:0]    pc_mem_d    [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic empty;
    logic bypass;
    logic push;
    logic pop;

    always_comb begin
        empty  = (count_q == '0);
        bypass = 1'b0;
`ifdef FETCH_BUFFER_BYPASS_EN
        bypass = empty && in_valid_i && !flush_i;
`endif
        in_ready_o  = (count_q < CNT_W'(DEPTH));
        out_valid_o = !empty || bypass;
        out_instr_o = '0;
        out_pc_o    = '0;
        if (!empty) begin
            out_instr_o = instr_mem_q[head_q];
            out_pc_o    = pc_mem_q[head_q];
        end else if (bypass) begin
            out_instr_o = in_instr_i;
            out_pc_o    = in_pc_i;
        end

        // A bypassed word taken by decode this cycle never enters storage.
        push = in_valid_i && in_ready_o && !flush_i && !(bypass && out_ready_i);
        pop  = !empty && out_ready_i && !flush_i;

        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;

        if (push) begin
            instr_mem_d[tail_q] = in_instr_i;
            pc_mem_d[tail_q]    = in_pc_i;
            tail_d              = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is left uncleared by reset/flush; count gates every read.
    always_ff @(posedge clk) begin
        instr_mem_q <= instr_mem_d;
        pc_mem_q    <= pc_mem_d;
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized + directed bench for fetch_buffer against a queue-based reference model.
// Honours FETCH_BUFFER_BYPASS_EN the same way as the design build.
module tb_fetch_buffer;

    localparam int DEPTH   = 8;
    localparam int INSTR_W = 32;
    localparam int PC_W    = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [INSTR_W-1:0] in_instr_i;
    logic [PC_W-1:0]    in_pc_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [INSTR_W-1:0] out_instr_o;
    logic [PC_W-1:0]    out_pc_o;
    logic [3:0]         count_o;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    logic [INSTR_W-1:0] q_instr [$];
    logic [PC_W-1:0]    q_pc    [$];

    always #5 clk = ~clk;

    fetch_buffer #(.DEPTH(DEPTH), .INSTR_W(INSTR_W), .PC_W(PC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_instr_i  (in_instr_i),
        .in_pc_i     (in_pc_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_instr_o (out_instr_o),
        .out_pc_o    (out_pc_o),
        .count_o     (count_o)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance model at posedge.
    task automatic cycle(input logic r, input logic fl, input logic iv,
                         input logic [INSTR_W-1:0] instr, input logic [PC_W-1:0] pc,
                         input logic ordy);
        int unsigned n;
        logic        byp;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        rst = r; flush_i = fl; in_valid_i = iv; in_instr_i = instr; in_pc_i = pc; out_ready_i = ordy;
        n   = q_instr.size();
        byp = 1'b0;
`ifdef FETCH_BUFFER_BYPASS_EN
        byp = (n == 0) && iv && !fl;
`endif
        exp_valid = (n != 0) || byp;
        exp_instr = '0;
        exp_pc    = '0;
        if (n != 0) begin
            exp_instr = q_instr[0];
            exp_pc    = 32'(q_pc[0]);
        end else if (byp) begin
            exp_instr = instr;
            exp_pc    = 32'(pc);
        end
        @(negedge clk);
        check("count",     32'(count_o),     n);
        check("in_ready",  32'(in_ready_o),  32'(n < DEPTH));
        check("out_valid", 32'(out_valid_o), 32'(exp_valid));
        check("out_instr", out_instr_o,      exp_instr);
        check("out_pc",    32'(out_pc_o),    exp_pc);
        @(posedge clk);
        if (r || fl) begin
            q_instr.delete();
            q_pc.delete();
        end else if (byp) begin
            if (!ordy) begin
                q_instr.push_back(instr);
                q_pc.push_back(pc);
            end
        end else begin
            if (n != 0 && ordy) begin
                void'(q_instr.pop_front());
                void'(q_pc.pop_front());
            end
            if (iv && n < DEPTH) begin
                q_instr.push_back(instr);
                q_pc.push_back(pc);
            end
        end
        #1;
    endtask

    task automatic idle(input int unsigned cycles, input logic ordy);
        for (int unsigned i = 0; i < cycles; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0, ordy);
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_instr_i = '0; in_pc_i = '0; out_ready_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state, then three pushes held, then ordered drain.
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0013, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0010_0093, 8'h04, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0020_0113, 8'h08, 1'b0);
        idle(4, 1'b1);

        // Fill to full, offer a 9th, pop one, push again across the wrap.
        for (int unsigned i = 0; i < 9; i++)
            cycle(1'b0, 1'b0, 1'b1, 32'hA000_0000 + i, 8'(i * 4), 1'b0);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 32'hA000_00FF, 8'hFC, 1'b0);
        idle(10, 1'b1);

        // Steady push+pop at occupancy 4.
        for (int unsigned i = 0; i < 4; i++)
            cycle(1'b0, 1'b0, 1'b1, 32'hB000_0000 + i, 8'(i), 1'b0);
        for (int unsigned i = 4; i < 24; i++)
            cycle(1'b0, 1'b0, 1'b1, 32'hB000_0000 + i, 8'(i), 1'b1);
        idle(6, 1'b1);

        // Flush with push and pop requested in the same cycle.
        for (int unsigned i = 0; i < 5; i++)
            cycle(1'b0, 1'b0, 1'b1, 32'hC000_0000 + i, 8'(i), 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 32'hC000_00EE, 8'hEE, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 32'hC000_0077, 8'h77, 1'b0);
        idle(3, 1'b1);

        // Reset while holding six entries.
        for (int unsigned i = 0; i < 6; i++)
            cycle(1'b0, 1'b0, 1'b1, 32'hD000_0000 + i, 8'(i), 1'b0);
        cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'hD000_0055, 8'h55, 1'b0);
        idle(3, 1'b1);

        // Empty-buffer push with decode ready (bypass case when enabled).
        cycle(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 8'h10, 1'b1);
        idle(3, 1'b1);

        for (int unsigned i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) < 6),
                  $urandom, 8'($urandom),
                  ($urandom_range(0, 9) < 5));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
